// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 VGA timing constants, derived active-area bounds, RGB565
// colour constants, the sprite-position handshake state type and a small
// clamp helper. Used by the timing generator and the pixel-source stages.
// -----------------------------------------------------------------------------
package vga_pkg;

   // Horizontal timing, in pixel clocks: sync, back porch, active, front porch, total
   localparam int SA = 96;
   localparam int SB = 48;
   localparam int SC = 640;
   localparam int SD = 16;
   localparam int SE = SA + SB + SC + SD;   // 800

   // Vertical timing, in lines: sync, back porch, active, front porch, total
   localparam int SO = 2;
   localparam int SP = 33;
   localparam int SQ = 480;
   localparam int SR = 10;
   localparam int SS = SO + SP + SQ + SR;   // 525

   localparam int H_ACT = SC;
   localparam int V_ACT = SQ;

   // Counter-width versions of the bounds, so compares need no width juggling
   localparam logic [9:0] HSTART = 10'(SA + SB);          // 144
   localparam logic [9:0] HEND   = 10'(SA + SB + SC);     // 784 (exclusive)
   localparam logic [9:0] VSTART = 10'(SO + SP);          // 35
   localparam logic [9:0] VEND   = 10'(SO + SP + SQ);     // 515 (exclusive)
   localparam logic [9:0] H_LAST = 10'(SE - 1);           // 799
   localparam logic [9:0] V_LAST = 10'(SS - 1);           // 524

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t RGB_BLACK = 16'h0000;
   localparam rgb565_t RGB_RED   = 16'hF800;
   localparam rgb565_t RGB_GREEN = 16'h07E0;
   localparam rgb565_t RGB_BLUE  = 16'h001F;
   localparam rgb565_t RGB_WHITE = 16'hFFFF;

   // Sprite position handshake states
   typedef enum logic [1:0] {
      PS_IDLE,
      PS_PEND,
      PS_ACKD
   } pos_state_t;

   function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/vga_posreg.sv
// -----------------------------------------------------------------------------
// vga_posreg
// Sprite position register with request/acknowledge handshake. A request is
// clamped and captured into a shadow pair, then copied to the live offsets
// only at the frame boundary so a frame never shows two sprite positions.
//
// Ports
//   i_clk       pixel clock
//   i_reset     synchronous, active-high reset
//   i_boundary  high during the last pixel of the frame (iCH==799, iCV==524)
//   i_req       position-change request (level)
//   i_x, i_y    requested offsets inside the active area
//   o_ack       one-cycle acknowledge, the cycle after the applying boundary
//   o_xoff      live horizontal offset
//   o_yoff      live vertical offset
// -----------------------------------------------------------------------------
module vga_posreg
   import vga_pkg::*;
#(
   parameter int XSIZE = 128,
   parameter int YSIZE = 128,
   parameter int XOFF  = 256,
   parameter int YOFF  = 176
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_boundary,
   input  logic       i_req,
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   output logic       o_ack,
   output logic [9:0] o_xoff,
   output logic [9:0] o_yoff
);

   // Largest offsets that still keep the whole sprite inside the active area
   localparam logic [9:0] XMAX = 10'(H_ACT - XSIZE);
   localparam logic [9:0] YMAX = 10'(V_ACT - YSIZE);

   pos_state_t r_state, w_state_next;
   logic       w_capture, w_apply;
   logic [9:0] r_shadow_x, r_shadow_y;
   logic [9:0] r_xoff, r_yoff;
   logic       r_ack;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= PS_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_apply      = 1'b0;
      case (r_state)
         PS_IDLE: if (i_req) begin
            w_capture    = 1'b1;
            w_state_next = PS_PEND;
         end
         PS_PEND: if (i_boundary) begin
            w_apply      = 1'b1;
            w_state_next = PS_ACKD;
         end
         // A level request still high after its ACK must not start another cycle
         PS_ACKD: if (!i_req) w_state_next = PS_IDLE;
         default: w_state_next = PS_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shadow_x <= 10'(XOFF);
         r_shadow_y <= 10'(YOFF);
         r_xoff     <= 10'(XOFF);
         r_yoff     <= 10'(YOFF);
         r_ack      <= 1'b0;
      end else begin
         r_ack <= w_apply;
         if (w_capture) begin
            r_shadow_x <= clamp10(i_x, XMAX);
            r_shadow_y <= clamp10(i_y, YMAX);
         end
         if (w_apply) begin
            r_xoff <= r_shadow_x;
            r_yoff <= r_shadow_y;
         end
      end
   end

   assign o_ack  = r_ack;
   assign o_xoff = r_xoff;
   assign o_yoff = r_yoff;

endmodule

// File: rtl/vga_imgmod.sv
// -----------------------------------------------------------------------------
// vga_imgmod
// Pixel source between the VGA timing generator and the DAC. Places a sprite
// read from an external synchronous ROM at a movable position, fills the rest
// of the active area with BG, blanks outside it, and delays the syncs so they
// leave on the same edge as their pixel (three registers on both paths).
//
// Ports
//   CLOCK, RESET          pixel clock, synchronous active-high reset
//   iH, iV                raw sync levels (active low)
//   iCH, iCV              horizontal / vertical counters
//   ROM_ADDR              {row, col} of the sprite texel, held outside the window
//   ROM_DATA              RGB565 word, valid one edge after ROM_ADDR
//   POS_REQ, POS_X, POS_Y position-change request and requested offsets
//   POS_ACK               one-cycle acknowledge
//   VGA_HSYNC, VGA_VSYNC  delayed syncs
//   VGAD                  RGB565 pixel
// -----------------------------------------------------------------------------
module vga_imgmod
   import vga_pkg::*;
#(
   parameter int      XSIZE = 128,
   parameter int      YSIZE = 128,
   parameter int      XOFF  = 256,
   parameter int      YOFF  = 176,
   parameter rgb565_t BG    = RGB_BLACK
) (
   input  logic                                   CLOCK,
   input  logic                                   RESET,
   input  logic                                   iH,
   input  logic                                   iV,
   input  logic [9:0]                             iCH,
   input  logic [9:0]                             iCV,
   output logic [$clog2(XSIZE)+$clog2(YSIZE)-1:0] ROM_ADDR,
   input  logic [15:0]                            ROM_DATA,
   input  logic                                   POS_REQ,
   input  logic [9:0]                             POS_X,
   input  logic [9:0]                             POS_Y,
   output logic                                   POS_ACK,
   output logic                                   VGA_HSYNC,
   output logic                                   VGA_VSYNC,
   output logic [15:0]                            VGAD
);

   localparam int          XB   = $clog2(XSIZE);
   localparam int          YB   = $clog2(YSIZE);
   localparam logic [10:0] XS11 = 11'(XSIZE);
   localparam logic [10:0] YS11 = 11'(YSIZE);

   logic [9:0]  w_xoff, w_yoff;
   logic        w_boundary;
   logic [10:0] w_ch, w_cv, w_hs, w_vs;
   logic        w_in_win, w_active;
   logic [XB-1:0] w_col;
   logic [YB-1:0] w_row;
   rgb565_t     w_pix;

   logic          r_win1, r_act1, r_win2, r_act2;
   logic [XB+YB-1:0] r_addr;
   logic [2:0]    r_hs_pipe, r_vs_pipe;
   rgb565_t       r_pix;

   assign w_boundary = (iCH == H_LAST) && (iCV == V_LAST);

   vga_posreg #(
      .XSIZE(XSIZE),
      .YSIZE(YSIZE),
      .XOFF (XOFF),
      .YOFF (YOFF)
   ) u_posreg (
      .i_clk     (CLOCK),
      .i_reset   (RESET),
      .i_boundary(w_boundary),
      .i_req     (POS_REQ),
      .i_x       (POS_X),
      .i_y       (POS_Y),
      .o_ack     (POS_ACK),
      .o_xoff    (w_xoff),
      .o_yoff    (w_yoff)
   );

   // Window bounds in 11 bits: the right/bottom edge can exceed 10-bit range
   // for unclamped arithmetic, and must not wrap back into the frame.
   assign w_ch = {1'b0, iCH};
   assign w_cv = {1'b0, iCV};
   assign w_hs = {1'b0, HSTART} + {1'b0, w_xoff};
   assign w_vs = {1'b0, VSTART} + {1'b0, w_yoff};

   assign w_in_win = (w_ch >= w_hs) && (w_ch < w_hs + XS11) &&
                     (w_cv >= w_vs) && (w_cv < w_vs + YS11);
   assign w_active = (iCH >= HSTART) && (iCH < HEND) &&
                     (iCV >= VSTART) && (iCV < VEND);

   // Only the low bits of the in-window distance are needed, and those depend
   // only on the low bits of the operands.
   assign w_col = w_ch[XB-1:0] - w_hs[XB-1:0];
   assign w_row = w_cv[YB-1:0] - w_vs[YB-1:0];

   // Stage 2 flags select the ROM word that the ROM registered one edge earlier
   assign w_pix = r_win2 ? ROM_DATA : (r_act2 ? BG : RGB_BLACK);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_win1    <= 1'b0;
         r_act1    <= 1'b0;
         r_win2    <= 1'b0;
         r_act2    <= 1'b0;
         r_addr    <= '0;
         r_hs_pipe <= 3'b111;
         r_vs_pipe <= 3'b111;
         r_pix     <= RGB_BLACK;
      end else begin
         r_win1    <= w_in_win;
         r_act1    <= w_active;
         r_win2    <= r_win1;
         r_act2    <= r_act1;
         if (w_in_win) r_addr <= {w_row, w_col};
         r_hs_pipe <= {r_hs_pipe[1:0], iH};
         r_vs_pipe <= {r_vs_pipe[1:0], iV};
         r_pix     <= w_pix;
      end
   end

   assign ROM_ADDR  = r_addr;
   assign VGA_HSYNC = r_hs_pipe[2];
   assign VGA_VSYNC = r_vs_pipe[2];
   assign VGAD      = r_pix;

endmodule

// File: tb/tb_vga_imgmod.sv
// -----------------------------------------------------------------------------
// tb_vga_imgmod
// Directed bench for vga_imgmod. Counter values are driven directly (jumping
// around the frame), a ROM model returns its address as data, and each driven
// pixel's expected sync/pixel triple is queued and compared when it emerges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_imgmod;

   localparam logic [15:0] BGC = 16'hF800;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        iH = 1'b1, iV = 1'b1;
   logic [9:0]  iCH = '0, iCV = '0;
   logic [13:0] rom_addr;
   logic [15:0] rom_data;
   logic        POS_REQ = 1'b0;
   logic [9:0]  POS_X = '0, POS_Y = '0;
   logic        POS_ACK;
   logic        VGA_HSYNC, VGA_VSYNC;
   logic [15:0] VGAD;

   always #20 clk = ~clk;

   // Synchronous ROM: registers the address, data follows the edge
   always_ff @(posedge clk) rom_data <= {2'b00, rom_addr};

   vga_imgmod #(.BG(BGC)) dut (
      .CLOCK    (clk),
      .RESET    (RESET),
      .iH       (iH),
      .iV       (iV),
      .iCH      (iCH),
      .iCV      (iCV),
      .ROM_ADDR (rom_addr),
      .ROM_DATA (rom_data),
      .POS_REQ  (POS_REQ),
      .POS_X    (POS_X),
      .POS_Y    (POS_Y),
      .POS_ACK  (POS_ACK),
      .VGA_HSYNC(VGA_HSYNC),
      .VGA_VSYNC(VGA_VSYNC),
      .VGAD     (VGAD)
   );

   typedef struct {
      int          ch;
      int          cv;
      logic        hs;
      logic        vs;
      logic [15:0] pix;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_xoff = 256;
   int   m_yoff = 176;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_pix(input int ch, input int cv, input int xo, input int yo);
      int hs = 144 + xo;
      int vs = 35 + yo;
      if (ch >= hs && ch < hs + 128 && cv >= vs && cv < vs + 128)
         return 16'(((cv - vs) << 7) + (ch - hs));
      if (ch >= 144 && ch < 784 && cv >= 35 && cv < 515)
         return BGC;
      return 16'h0000;
   endfunction

   // Drive one pixel, clock it in, then check ACK and the pixel driven two steps ago
   task automatic step(input int ch, input int cv, input logic ack_exp);
      exp_t e, g;
      iCH = 10'(ch);
      iCV = 10'(cv);
      iH  = (ch >= 96);
      iV  = (cv >= 2);
      e.ch = ch; e.cv = cv; e.hs = iH; e.vs = iV;
      e.pix = exp_pix(ch, cv, m_xoff, m_yoff);
      sb.push_back(e);
      @(posedge clk); #1;
      check($sformatf("pos_ack@%0d,%0d", ch, cv), {15'd0, POS_ACK}, {15'd0, ack_exp});
      if (sb.size() == 3) begin
         g = sb.pop_front();
         $display("txn ch=%0d cv=%0d vgad=%h hsync=%b vsync=%b ack=%b",
                  g.ch, g.cv, VGAD, VGA_HSYNC, VGA_VSYNC, POS_ACK);
         check($sformatf("vgad@%0d,%0d", g.ch, g.cv), VGAD, g.pix);
         check($sformatf("hsync@%0d,%0d", g.ch, g.cv), {15'd0, VGA_HSYNC}, {15'd0, g.hs});
         check($sformatf("vsync@%0d,%0d", g.ch, g.cv), {15'd0, VGA_VSYNC}, {15'd0, g.vs});
      end
   endtask

   task automatic do_reset(input int ch, input int cv, input int ncyc);
      exp_t r;
      RESET = 1'b1;
      iCH = 10'(ch);
      iCV = 10'(cv);
      iH  = (ch >= 96);
      iV  = (cv >= 2);
      repeat (ncyc) @(posedge clk);
      #1;
      $display("txn reset ch=%0d cv=%0d vgad=%h hsync=%b vsync=%b addr=%h ack=%b",
               ch, cv, VGAD, VGA_HSYNC, VGA_VSYNC, rom_addr, POS_ACK);
      check("reset_vgad",  VGAD, 16'h0000);
      check("reset_hsync", {15'd0, VGA_HSYNC}, 16'd1);
      check("reset_vsync", {15'd0, VGA_VSYNC}, 16'd1);
      check("reset_addr",  {2'b00, rom_addr}, 16'h0000);
      check("reset_ack",   {15'd0, POS_ACK}, 16'd0);
      RESET = 1'b0;
      m_xoff = 256;
      m_yoff = 176;
      // The two pipeline stages still hold reset values
      sb.delete();
      r.ch = -1; r.cv = -1; r.hs = 1'b1; r.vs = 1'b1; r.pix = 16'h0000;
      sb.push_back(r);
      sb.push_back(r);
   endtask

   initial begin
      // Power-on reset
      do_reset(450, 300, 2);

      // Default sprite at 256/176: window x 400..527, y 211..338
      for (int c = 396; c <= 404; c++) step(c, 211, 1'b0);
      step(401, 212, 1'b0);
      check("rom_addr_401_212", {2'b00, rom_addr}, 16'h0081);
      step(527, 338, 1'b0);
      check("rom_addr_527_338", {2'b00, rom_addr}, 16'h3FFF);
      step(528, 338, 1'b0);
      step(527, 339, 1'b0);
      step(50, 211, 1'b0);
      for (int c = 142; c <= 145; c++) step(c, 211, 1'b0);
      step(783, 211, 1'b0);
      step(784, 211, 1'b0);
      step(300, 34, 1'b0);
      step(300, 35, 1'b0);
      step(300, 514, 1'b0);
      step(300, 515, 1'b0);

      // Sync edges travel with their pixels
      step(798, 100, 1'b0);
      step(799, 100, 1'b0);
      step(0, 100, 1'b0);
      step(1, 100, 1'b0);
      step(5, 1, 1'b0);
      step(5, 2, 1'b0);

      // Mid-frame request, X clamps to 512; current frame unchanged
      POS_REQ = 1'b1; POS_X = 10'd700; POS_Y = 10'd10;
      step(400, 211, 1'b0);
      step(656, 45, 1'b0);
      step(798, 524, 1'b0);
      step(799, 524, 1'b1);
      m_xoff = 512; m_yoff = 10;
      step(0, 0, 1'b0);
      POS_REQ = 1'b0;
      step(655, 45, 1'b0);
      step(656, 45, 1'b0);
      step(657, 46, 1'b0);
      check("rom_addr_657_46", {2'b00, rom_addr}, 16'h0081);
      step(783, 172, 1'b0);
      step(784, 172, 1'b0);
      step(656, 44, 1'b0);
      step(656, 173, 1'b0);

      // Request raised in the boundary cycle: applied one frame later, Y clamps to 352
      POS_REQ = 1'b1; POS_X = 10'd0; POS_Y = 10'd400;
      step(799, 524, 1'b0);
      step(656, 45, 1'b0);
      step(400, 211, 1'b0);
      step(799, 524, 1'b1);
      m_xoff = 0; m_yoff = 352;
      step(0, 0, 1'b0);
      step(144, 387, 1'b0);
      step(143, 387, 1'b0);
      step(271, 514, 1'b0);
      step(272, 514, 1'b0);
      // Held request across further boundaries: no second ACK, no change
      step(799, 524, 1'b0);
      step(144, 387, 1'b0);
      step(799, 524, 1'b0);
      step(144, 387, 1'b0);
      POS_REQ = 1'b0;
      step(5, 5, 1'b0);

      // Reset with a request pending: discarded, offsets back to 256/176
      POS_REQ = 1'b1; POS_X = 10'd100; POS_Y = 10'd100;
      step(300, 200, 1'b0);
      step(200, 400, 1'b0);
      step(50, 1, 1'b0);
      step(60, 1, 1'b0);
      step(70, 1, 1'b0);
      POS_REQ = 1'b0;
      do_reset(450, 300, 1);
      step(799, 524, 1'b0);
      step(0, 0, 1'b0);
      step(244, 135, 1'b0);
      step(400, 211, 1'b0);
      step(399, 211, 1'b0);
      step(10, 10, 1'b0);
      step(10, 10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_imgmod.md
# vga_imgmod

Pixel-source stage sitting directly downstream of the VGA timing generator and upstream of the DAC pins. Takes the generator's raw sync levels and H/V counters, fetches a 128x128 RGB565 sprite from an external synchronous ROM at a movable on-screen position, and re-emits syncs and pixel data aligned through a fixed pipeline. Sprite position changes through a request/acknowledge port and are applied only at frame boundaries, so a frame never tears.

## Interface
- XSIZE, 128, sprite width in pixels (power of two, fixed by ROM)
- YSIZE, 128, sprite height in pixels
- XOFF, 256, reset horizontal offset inside the 640-pixel active area
- YOFF, 176, reset vertical offset inside the 480-line active area
- BG, 16'h0000, RGB565 colour for active-area pixels outside the sprite
- CLOCK  in  1  pixel clock (25 MHz class)
- RESET  in  1  synchronous, active-high reset
- iH, iV  in  1 each  sync levels from timing generator (active low)
- iCH  in  10  horizontal counter, 0..799
- iCV  in  10  vertical counter, 0..524
- ROM_ADDR  out  14  sprite address, {row[6:0], col[6:0]}
- ROM_DATA  in  16  RGB565 word; ROM registers ROM_ADDR on a clock edge and presents data after that edge
- POS_REQ  in  1  position-change request, level
- POS_X, POS_Y  in  10 each  requested offset; stable while POS_REQ high
- POS_ACK  out  1  one-cycle acknowledge
- VGA_HSYNC, VGA_VSYNC  out  1 each  delayed syncs
- VGAD  out  16  RGB565 pixel

## Operation
- Active area: HSTART = SA+SB = 144 <= iCH < 784; VSTART = SO+SP = 35 <= iCV < 515. Outside it VGAD = 0 regardless of BG.
- Sprite window: HSTART+xoff <= iCH < HSTART+xoff+XSIZE and VSTART+yoff <= iCV < VSTART+yoff+YSIZE. Compare in 11-bit arithmetic; no wrap.
- ROM_ADDR = {(iCV-VSTART-yoff)[6:0], (iCH-HSTART-xoff)[6:0]} when in window, else held at previous value.
- Pixel: in window -> ROM_DATA; active but out of window -> BG; else 0.
- Position FSM (states IDLE, PEND, ACKD):
  - IDLE: POS_REQ=1 -> capture POS_X/POS_Y into shadow, go PEND. Clamp: X > 640-XSIZE (512) -> 512; Y > 480-YSIZE (352) -> 352.
  - PEND: frame boundary (iCH==799 && iCV==524) -> xoff/yoff <= shadow, POS_ACK=1 for the next cycle, go ACKD.
  - ACKD: wait for POS_REQ=0, then IDLE. A request held high never re-triggers.
- Request arriving in the boundary cycle itself: captured that cycle, applied at the following boundary.
- Reset mid-operation: pending request discarded without ACK; xoff/yoff return to XOFF/YOFF; requester must drop and re-raise POS_REQ.

## Timing
- Pipeline: stage 1 register (window flags, active flag, ROM_ADDR, syncs) at edge n; ROM at edge n+1; output register at edge n+2. Inputs of cycle n appear on VGAD/VGA_HSYNC/VGA_VSYNC after edge n+2. Syncs pass through three flops to match the data path exactly.
- ROM_ADDR is valid after edge n.
- POS_ACK high exactly one cycle, beginning the cycle after the boundary cycle; new offsets affect the window computation of the first pixel of the next frame (iCH=0, iCV=0).
- Reset values: VGA_HSYNC=1, VGA_VSYNC=1, VGAD=0, ROM_ADDR=0, POS_ACK=0, FSM IDLE, xoff=XOFF, yoff=YOFF, all pipeline flags 0.

## Structure
- Shared package vga_pkg: SA..SE, SO..SS timing constants, HSTART, VSTART, active width/height, RGB565 colour constants; used by this block and the timing generator.
- Sub-module vga_posreg: handshake FSM, clamp and shadow/live offset registers; outputs xoff, yoff.
- Top holds the window compare, address generation and the three-stage alignment pipeline.

## Test plan
- Reset asserted mid-line -> next edge VGAD=0, syncs=1, ROM_ADDR=0, POS_ACK=0; offsets 256/176.
- Free-running generator, ROM model returns address as data -> at iCH=400, iCV=211 VGAD=0x0000 (addr 0) after three edges; at iCH=527, iCV=338 VGAD=0x3FFF.
- Active pixel outside sprite, BG=0xF800 -> VGAD=0xF800; blanking pixel (iCH=50) -> 0.
- POS_REQ with X=700, Y=10 mid-frame -> clamped to 512/10, POS_ACK one cycle after boundary, next frame sprite starts at iCH=656, iCV=45; no change in current frame.
- POS_REQ raised in the boundary cycle -> applied one frame later; REQ held high for 3 frames -> exactly one ACK.
- Sync alignment: iH falling edge at cycle n -> VGA_HSYNC falls after edge n+2, same edge as matching pixel.
